// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the FSM state encoding and the sizing rule for the shared phase timer.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // The timer is loaded with (cycles - 1), so the largest phase length m needs clog2(m) bits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both stages clear on the synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock and gates the downstream reset.
// Define PLL_LOCK_SUPERVISOR_AUTORETRY_EN to re-reset the PLL after every lock timeout.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int STABLE_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pll_lock,
  input  logic             clr_status,
  output logic             pll_reset,
  output logic             rst_out_n,
  output logic             lock_lost,
  output logic             timeout,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int TW = cnt_width(RST_PULSE_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  localparam logic [TW-1:0]    RST_LOAD = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    STB_LOAD = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  pll_state_e       state_q;
  pll_state_e       state_d;
  logic [TW-1:0]    tmr_q;
  logic [TW-1:0]    tmr_d;
  logic             lock_s;
  logic             loss_evt;
  logic             timeout_evt;

  logic             pll_reset_q;
  logic             pll_reset_d;
  logic             rst_out_n_q;
  logic             rst_out_n_d;
  logic             lock_lost_q;
  logic             lock_lost_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [CNT_W-1:0] relock_cnt_q;
  logic [CNT_W-1:0] relock_cnt_d;
  logic [CNT_W-1:0] retry_cnt_q;
  logic [CNT_W-1:0] retry_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  sync_2ff u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= PLL_RST;
      tmr_q        <= RST_LOAD;
      pll_reset_q  <= 1'b1;
      rst_out_n_q  <= 1'b0;
      lock_lost_q  <= 1'b0;
      timeout_q    <= 1'b0;
      relock_cnt_q <= '0;
      retry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pll_reset_q  <= pll_reset_d;
      rst_out_n_q  <= rst_out_n_d;
      lock_lost_q  <= lock_lost_d;
      timeout_q    <= timeout_d;
      relock_cnt_q <= relock_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  // One down-counter times every phase; each transition reloads it for the phase being entered.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (tmr_q == '0) begin
          state_d = WAIT_LOCK;
          tmr_d   = TMO_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          tmr_d   = STB_LOAD;
        end else if (tmr_q == '0) begin
          timeout_evt = 1'b1;
`ifdef PLL_LOCK_SUPERVISOR_AUTORETRY_EN
          state_d = PLL_RST;
          tmr_d   = RST_LOAD;
`else
          tmr_d   = TMO_LOAD;
`endif
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          tmr_d   = TMO_LOAD;
        end else if (tmr_q == '0) begin
          state_d = RUN;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          tmr_d    = TMO_LOAD;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
        tmr_d   = RST_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    pll_reset_d  = (state_d == PLL_RST);
    rst_out_n_d  = (state_d == RUN);
    lock_lost_d  = lock_lost_q;
    timeout_d    = timeout_q;
    relock_cnt_d = relock_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    if (clr_status) begin
      lock_lost_d  = 1'b0;
      timeout_d    = 1'b0;
      relock_cnt_d = '0;
      retry_cnt_d  = '0;
    end
    if (loss_evt) begin
      lock_lost_d  = 1'b1;
      relock_cnt_d = clr_status ? CNT_W'(1) : sat_inc(relock_cnt_q);
    end
    if (timeout_evt) begin
      timeout_d   = 1'b1;
      retry_cnt_d = clr_status ? CNT_W'(1) : sat_inc(retry_cnt_q);
    end
  end

  assign pll_reset  = pll_reset_q;
  assign rst_out_n  = rst_out_n_q;
  assign lock_lost  = lock_lost_q;
  assign timeout    = timeout_q;
  assign relock_cnt = relock_cnt_q;
  assign retry_cnt  = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short phase lengths (4/8/32, 4-bit counters).
// Expected timeout behaviour follows PLL_LOCK_SUPERVISOR_AUTORETRY_EN when it is defined.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int RST_PULSE = 4;
  localparam int STABLE    = 8;
  localparam int TMO       = 32;
  localparam int CW        = 4;
`ifdef PLL_LOCK_SUPERVISOR_AUTORETRY_EN
  localparam int PERIOD    = TMO + RST_PULSE;
`else
  localparam int PERIOD    = TMO;
`endif
  localparam int FIRST_TMO = RST_PULSE + TMO - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pll_lock = 1'b0;
  logic          clr_status = 1'b0;
  logic          pll_reset;
  logic          rst_out_n;
  logic          lock_lost;
  logic          timeout;
  logic [CW-1:0] relock_cnt;
  logic [CW-1:0] retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          resetn;
    logic          pll_lock;
    logic          clr_status;
    logic          exp_pll_reset;
    logic          exp_rst_out_n;
    logic          exp_lock_lost;
    logic          exp_timeout;
    logic [CW-1:0] exp_relock;
    logic [CW-1:0] exp_retry;
  } vec_t;

  vec_t vecs[26];

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES (RST_PULSE),
    .STABLE_CYCLES    (STABLE),
    .TIMEOUT_CYCLES   (TMO),
    .CNT_W            (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .clr_status (clr_status),
    .pll_reset  (pll_reset),
    .rst_out_n  (rst_out_n),
    .lock_lost  (lock_lost),
    .timeout    (timeout),
    .relock_cnt (relock_cnt),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle just past the edge that samples them.
  task automatic apply_stimulus(input logic rn, input logic lk, input logic clr);
    resetn     = rn;
    pll_lock   = lk;
    clr_status = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic check_all(input string tag, input logic pr, input logic rn, input logic ll,
                           input logic to, input logic [CW-1:0] rc, input logic [CW-1:0] rt);
    check_output($sformatf("%s.pll_reset", tag), 32'(pll_reset), 32'(pr));
    check_output($sformatf("%s.rst_out_n", tag), 32'(rst_out_n), 32'(rn));
    check_output($sformatf("%s.lock_lost", tag), 32'(lock_lost), 32'(ll));
    check_output($sformatf("%s.timeout", tag), 32'(timeout), 32'(to));
    check_output($sformatf("%s.relock_cnt", tag), 32'(relock_cnt), 32'(rc));
    check_output($sformatf("%s.retry_cnt", tag), 32'(retry_cnt), 32'(rt));
  endtask

  // From RUN: a one-cycle lock dropout reaches lock_s two edges later, then 1 + 8 cycles of relock.
  task automatic lose_and_relock(input string tag, input logic clr_at_loss, input logic [CW-1:0] exp_relock);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output({tag, ".pre0_rst_out_n"}, 32'(rst_out_n), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output({tag, ".pre1_rst_out_n"}, 32'(rst_out_n), 32'd1);
    apply_stimulus(1'b1, 1'b1, clr_at_loss);
    check_all({tag, ".loss"}, 1'b0, 1'b0, 1'b1, 1'b0, exp_relock, 4'd0);
    for (int i = 0; i < STABLE; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output($sformatf("%s.relock%0d_rst_out_n", tag, i), 32'(rst_out_n), 32'd0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_all({tag, ".run"}, 1'b0, 1'b1, 1'b1, 1'b0, exp_relock, 4'd0);
  endtask

  initial begin
    int exp_rt;
    int ev_k;

    // Power-up: two reset cycles, then lock arrives at cycle 10 and RUN is reached after edge 20.
    for (int i = 0; i < 2; i++) begin
      vecs[i] = '{resetn: 1'b0, pll_lock: 1'b0, clr_status: 1'b0, exp_pll_reset: 1'b1,
                  exp_rst_out_n: 1'b0, exp_lock_lost: 1'b0, exp_timeout: 1'b0,
                  exp_relock: 4'd0, exp_retry: 4'd0};
    end
    for (int k = 0; k < 24; k++) begin
      vecs[2+k] = '{resetn: 1'b1, pll_lock: (k >= 10), clr_status: 1'b0, exp_pll_reset: (k <= 2),
                    exp_rst_out_n: (k >= 20), exp_lock_lost: 1'b0, exp_timeout: 1'b0,
                    exp_relock: 4'd0, exp_retry: 4'd0};
    end

    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].resetn, vecs[i].pll_lock, vecs[i].clr_status);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pll_reset, vecs[i].exp_rst_out_n,
                vecs[i].exp_lock_lost, vecs[i].exp_timeout, vecs[i].exp_relock, vecs[i].exp_retry);
    end

    lose_and_relock("loss1", 1'b0, 4'd1);
    lose_and_relock("loss_clr", 1'b1, 4'd1);
    lose_and_relock("loss2", 1'b0, 4'd2);

    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_all("reset_in_run", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Lock glitch after five stable cycles in STABILIZE restarts the stable count.
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, (k != 8), 1'b0);
      check_output($sformatf("glitch%0d.pll_reset", k), 32'(pll_reset), 32'(k <= 2));
      check_output($sformatf("glitch%0d.rst_out_n", k), 32'(rst_out_n), 32'(k >= 19));
      check_output($sformatf("glitch%0d.lock_lost", k), 32'(lock_lost), 32'd0);
    end

    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_all("reset_before_tmo", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // No lock at all: timeouts every PERIOD cycles after the first one at edge FIRST_TMO.
    for (int k = 0; k < 640; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      exp_rt = (k >= FIRST_TMO) ? ((k - FIRST_TMO) / PERIOD + 1) : 0;
      if (exp_rt > 15) exp_rt = 15;
`ifdef PLL_LOCK_SUPERVISOR_AUTORETRY_EN
      check_output($sformatf("tmo%0d.pll_reset", k), 32'(pll_reset),
                   32'((k <= 2) || ((k >= FIRST_TMO) && (((k - FIRST_TMO) % PERIOD) < RST_PULSE))));
`else
      check_output($sformatf("tmo%0d.pll_reset", k), 32'(pll_reset), 32'(k <= 2));
`endif
      check_output($sformatf("tmo%0d.rst_out_n", k), 32'(rst_out_n), 32'd0);
      check_output($sformatf("tmo%0d.timeout", k), 32'(timeout), 32'(k >= FIRST_TMO));
      check_output($sformatf("tmo%0d.retry_cnt", k), 32'(retry_cnt), 32'(exp_rt));
    end

    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("clr_only.timeout", 32'(timeout), 32'd0);
    check_output("clr_only.retry_cnt", 32'(retry_cnt), 32'd0);

    ev_k = FIRST_TMO + PERIOD * ((640 - FIRST_TMO) / PERIOD + 1);
    for (int k = 641; k < ev_k; k++) apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("pre_clr_tmo.retry_cnt", 32'(retry_cnt), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("clr_tmo.timeout", 32'(timeout), 32'd1);
    check_output("clr_tmo.retry_cnt", 32'(retry_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
